// File: rtl/bitop_arbiter.sv
// Two-requester round-robin front end for a registered AND/XOR unit with a
// single-entry valid/ready result register. `BITOP_ARB_EXT_OPS_EN adds OR/XNOR.
module bitop_arbiter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [1:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [1:0]   req1_op,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic         res_id,
   output logic [7:0]   res_cnt,
   output logic         busy
);

   logic         last_r;
   logic         gnt0_s;
   logic         gnt1_s;
   logic         can_accept_s;
   logic [W-1:0] op_res_s;

   // Without the extension only op[0] matters, so 10/11 alias AND/XOR.
   function automatic logic [W-1:0] bitop(input logic [1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
`ifdef BITOP_ARB_EXT_OPS_EN
      case (op)
         2'b00:   r = a & b;
         2'b01:   r = a ^ b;
         2'b10:   r = a | b;
         2'b11:   r = ~(a ^ b);
         default: r = a & b;
      endcase
`else
      case (op)
         2'b00, 2'b10: r = a & b;
         2'b01, 2'b11: r = a ^ b;
         default:      r = a & b;
      endcase
`endif
      return r;
   endfunction

   // Round-robin grant, acceptance gating and the selected operation result.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (req0_valid && req1_valid) begin
         if (last_r) begin
            gnt0_s = 1'b1;
         end else begin
            gnt1_s = 1'b1;
         end
      end else if (req0_valid) begin
         gnt0_s = 1'b1;
      end else if (req1_valid) begin
         gnt1_s = 1'b1;
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
      can_accept_s = !res_valid || res_ready;
      req0_ready   = gnt0_s && can_accept_s && !rst;
      req1_ready   = gnt1_s && can_accept_s && !rst;
      if (gnt1_s) begin
         op_res_s = bitop(req1_op, req1_a, req1_b);
      end else begin
         op_res_s = bitop(req0_op, req0_a, req0_b);
      end
   end

   // Result register, pointer and handshake counter; pointer moves only on a transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= {W{1'b0}};
         res_id    <= 1'b0;
         res_cnt   <= 8'd0;
         last_r    <= 1'b1;
      end else begin
         if (res_valid && res_ready) begin
            res_cnt <= res_cnt + 8'd1;
         end else begin
            res_cnt <= res_cnt;
         end
         if (req0_ready || req1_ready) begin
            res_data  <= op_res_s;
            res_id    <= req1_ready;
            res_valid <= 1'b1;
            last_r    <= req1_ready;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end else begin
            res_valid <= res_valid;
         end
      end
   end

   assign busy = res_valid;

endmodule

// File: tb/tb_bitop_arbiter.sv
// Self-checking bench for bitop_arbiter: directed vector table, hand-written
// corner sequences, then constrained-random traffic against a reference model.
module tb_bitop_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0] req0_op, req1_op;
   logic       res_valid, res_ready, res_id, busy;
   logic [7:0] res_data, res_cnt;

   int checks = 0;
   int errors = 0;
   logic cap_r0, cap_r1;

`ifdef BITOP_ARB_EXT_OPS_EN
   localparam logic [7:0] OP10_RES = 8'hAF;
   localparam logic [7:0] OP11_RES = 8'h5A;
`else
   localparam logic [7:0] OP10_RES = 8'h0A;
   localparam logic [7:0] OP11_RES = 8'hA5;
`endif

   always #5 clk = ~clk;

   bitop_arbiter #(.W(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
      .res_cnt(res_cnt), .busy(busy)
   );

   typedef struct {
      logic       v0; logic [7:0] a0; logic [7:0] b0; logic [1:0] op0;
      logic       v1; logic [7:0] a1; logic [7:0] b1; logic [1:0] op1;
      logic       rr;
      logic       e_r0; logic e_r1; logic e_valid; logic [7:0] e_data; logic e_id; logic [7:0] e_cnt;
   } vec_t;

   vec_t tbl[10];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Capture the combinational readies mid-cycle, then step past the active edge.
   task automatic tick;
      @(negedge clk);
      cap_r0 = req0_ready;
      cap_r1 = req1_ready;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
`ifdef BITOP_ARB_EXT_OPS_EN
      if (op == 2'd0) return a & b;
      if (op == 2'd1) return a ^ b;
      if (op == 2'd2) return a | b;
      return ~(a ^ b);
`else
      return (op % 2 == 1) ? (a ^ b) : (a & b);
`endif
   endfunction

   task automatic set_both;
      req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b00;
      req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h0F; req1_op = 2'b01;
   endtask

   initial begin
      logic       m_last, m_valid, m_id, e_r0, e_r1, win, hold0, hold1;
      logic [7:0] m_data, m_cnt;

      tbl[0] = '{1'b1, 8'hF0, 8'h3C, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 1'b0, 8'd0};
      tbl[1] = '{1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 8'd1};
      tbl[2] = '{1'b1, 8'hF0, 8'h3C, 2'b00, 1'b1, 8'hAA, 8'h0F, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 8'd1};
      tbl[3] = '{1'b1, 8'hF0, 8'h3C, 2'b00, 1'b1, 8'hAA, 8'h0F, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 1'b0, 8'd2};
      tbl[4] = '{1'b1, 8'hF0, 8'h3C, 2'b00, 1'b1, 8'hAA, 8'h0F, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 8'd2};
      tbl[5] = '{1'b1, 8'hF0, 8'h3C, 2'b00, 1'b1, 8'hAA, 8'h0F, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 8'd3};
      tbl[6] = '{1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 8'hAA, 8'h0F, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, OP10_RES, 1'b1, 8'd4};
      tbl[7] = '{1'b1, 8'hAA, 8'h0F, 2'b11, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, OP11_RES, 1'b0, 8'd5};
      tbl[8] = '{1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, OP11_RES, 1'b0, 8'd5};
      tbl[9] = '{1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, OP11_RES, 1'b0, 8'd6};

      // Reset held two cycles with a pending request.
      rst = 1'b1; res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b00;
      req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 2'b00;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk1("rst_r0", cap_r0, 1'b0);
         chk1("rst_valid", res_valid, 1'b0);
         chk8("rst_cnt", res_cnt, 8'd0);
         chk8("rst_data", res_data, 8'd0);
      end
      rst = 1'b0;

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         req0_valid = tbl[i].v0; req0_a = tbl[i].a0; req0_b = tbl[i].b0; req0_op = tbl[i].op0;
         req1_valid = tbl[i].v1; req1_a = tbl[i].a1; req1_b = tbl[i].b1; req1_op = tbl[i].op1;
         res_ready  = tbl[i].rr;
         tick();
         chk1($sformatf("tbl%0d_r0", i), cap_r0, tbl[i].e_r0);
         chk1($sformatf("tbl%0d_r1", i), cap_r1, tbl[i].e_r1);
         chk1($sformatf("tbl%0d_valid", i), res_valid, tbl[i].e_valid);
         chk8($sformatf("tbl%0d_data", i), res_data, tbl[i].e_data);
         chk1($sformatf("tbl%0d_id", i), res_id, tbl[i].e_id);
         chk8($sformatf("tbl%0d_cnt", i), res_cnt, tbl[i].e_cnt);
      end

      // Contention from reset: grants 0,1,0,1 at one result per cycle.
      rst = 1'b1; tick(); rst = 1'b0;
      set_both(); res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1("cont_r0", cap_r0, (i % 2 == 0));
         chk1("cont_r1", cap_r1, (i % 2 == 1));
         chk1("cont_valid", res_valid, 1'b1);
         chk1("cont_id", res_id, (i % 2 == 1));
         chk8("cont_data", res_data, (i % 2 == 1) ? 8'hA5 : 8'h30);
      end

      // Backpressure: both blocked, result stable, pointer kept.
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("bp_r0", cap_r0, 1'b0);
         chk1("bp_r1", cap_r1, 1'b0);
         chk1("bp_valid", res_valid, 1'b1);
         chk8("bp_data", res_data, 8'hA5);
         chk1("bp_id", res_id, 1'b1);
      end
      res_ready = 1'b1;
      tick();
      chk1("rel_r0", cap_r0, 1'b1);
      chk1("rel_r1", cap_r1, 1'b0);
      chk1("rel_id", res_id, 1'b0);

      // Counter wrap after 256 handshakes.
      rst = 1'b1; tick(); rst = 1'b0;
      req1_valid = 1'b0; res_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         tick();
         if (i == 255) chk8("wrap_cnt_ff", res_cnt, 8'hFF);
      end
      chk8("wrap_cnt", res_cnt, 8'h00);
      chk1("wrap_valid", res_valid, 1'b1);

      // Reset while a result is stalled.
      req0_valid = 1'b0; res_ready = 1'b0;
      tick();
      chk1("stall_valid", res_valid, 1'b1);
      chk1("stall_busy", busy, 1'b1);
      rst = 1'b1; req0_valid = 1'b1;
      tick();
      chk1("mid_rst_r0", cap_r0, 1'b0);
      chk1("mid_rst_valid", res_valid, 1'b0);
      chk8("mid_rst_cnt", res_cnt, 8'd0);
      rst = 1'b0; set_both(); res_ready = 1'b1;
      tick();
      chk1("post_rst_r0", cap_r0, 1'b1);
      chk1("post_rst_r1", cap_r1, 1'b0);

      // Random traffic against the reference model.
      rst = 1'b1; tick(); rst = 1'b0;
      m_last = 1'b1; m_valid = 1'b0; m_data = 8'd0; m_id = 1'b0; m_cnt = 8'd0;
      hold0 = 1'b0; hold1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!hold0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
         end
         if (!hold1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
         end
         res_ready = ($urandom_range(0, 2) != 0);
         win  = (req0_valid && req1_valid) ? !m_last : !req0_valid;
         e_r0 = (!m_valid || res_ready) && (req0_valid || req1_valid) && (win == 1'b0);
         e_r1 = (!m_valid || res_ready) && (req0_valid || req1_valid) && (win == 1'b1);
         tick();
         chk1("rnd_r0", cap_r0, e_r0);
         chk1("rnd_r1", cap_r1, e_r1);
         if (m_valid && res_ready) m_cnt = m_cnt + 8'd1;
         if (e_r0 || e_r1) begin
            m_data  = win ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
            m_id    = win;
            m_valid = 1'b1;
            m_last  = win;
         end else if (res_ready) begin
            m_valid = 1'b0;
         end
         chk1("rnd_valid", res_valid, m_valid);
         chk1("rnd_busy", busy, m_valid);
         chk8("rnd_data", res_data, m_data);
         chk1("rnd_id", res_id, m_id);
         chk8("rnd_cnt", res_cnt, m_cnt);
         hold0 = req0_valid && !cap_r0;
         hold1 = req1_valid && !cap_r1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
